// File: rtl/regfile_wb_sink.sv
// rtl/regfile_wb_sink.sv - integer register file with write-back sink, bypass and load scoreboard
//
// Purpose:
//   32 x XLEN integer register file in the ID stage. Accepts one write per
//   cycle from WB and serves two combinational read ports to decode. A WB
//   write can be forwarded to a read in the same cycle. A per-register
//   load-pending scoreboard drives the decode stall for consumers of
//   in-flight loads.
//
// Ports:
//   clk, reset                                    clock, synchronous active-high reset
//   reg_write_en_w_i, rd_idx_w_i,
//   write_back_data_w_i, wb_is_load_w_i           write-back interface from WB
//   rs1_idx_d_i, rs2_idx_d_i                      read indices from decode
//   rs1_data_d_o, rs2_data_d_o                    read data to decode
//   load_issue_en_d_i, load_rd_idx_d_i            load leaving ID (sets the scoreboard)
//   rs1_used_d_i, rs2_used_d_i                    operand-use qualifiers for the stall
//   stall_d_o                                     ID must hold on a pending load
module regfile_wb_sink #(
    parameter int XLEN      = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reg_write_en_w_i,
    input  logic [4:0]      rd_idx_w_i,
    input  logic [XLEN-1:0] write_back_data_w_i,
    input  logic            wb_is_load_w_i,
    input  logic [4:0]      rs1_idx_d_i,
    input  logic [4:0]      rs2_idx_d_i,
    output logic [XLEN-1:0] rs1_data_d_o,
    output logic [XLEN-1:0] rs2_data_d_o,
    input  logic            load_issue_en_d_i,
    input  logic [4:0]      load_rd_idx_d_i,
    input  logic            rs1_used_d_i,
    input  logic            rs2_used_d_i,
    output logic            stall_d_o
);

    // Entry 0 exists only to keep indexing simple; it is never written or read.
    logic [XLEN-1:0] regs_q [32];
    logic [31:0]     pending_q;
    logic [31:0]     pending_d;

    logic wr_valid;
    logic clr_valid;
    logic set_valid;
    logic clr_now;

    assign wr_valid  = reg_write_en_w_i && (rd_idx_w_i != 5'd0);
    assign clr_valid = wr_valid && wb_is_load_w_i;
    assign set_valid = load_issue_en_d_i && (load_rd_idx_d_i != 5'd0);
    // A load result arriving this cycle releases its consumers early only
    // when the data itself is being forwarded.
    assign clr_now   = BYPASS_EN && clr_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[rd_idx_w_i] <= write_back_data_w_i;
        end
    end

    // Set is applied after clear so a new load to the same rd stays pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid) begin
            pending_d[rd_idx_w_i] = 1'b0;
        end
        if (set_valid) begin
            pending_d[load_rd_idx_d_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rs1_data_d_o = regs_q[rs1_idx_d_i];
        if (rs1_idx_d_i == 5'd0) begin
            rs1_data_d_o = '0;
        end else if (BYPASS_EN && reg_write_en_w_i && (rd_idx_w_i == rs1_idx_d_i)) begin
            rs1_data_d_o = write_back_data_w_i;
        end
    end

    always_comb begin
        rs2_data_d_o = regs_q[rs2_idx_d_i];
        if (rs2_idx_d_i == 5'd0) begin
            rs2_data_d_o = '0;
        end else if (BYPASS_EN && reg_write_en_w_i && (rd_idx_w_i == rs2_idx_d_i)) begin
            rs2_data_d_o = write_back_data_w_i;
        end
    end

    logic rs1_pend;
    logic rs2_pend;

    // pending_q[0] is held at 0, so x0 never stalls.
    assign rs1_pend  = pending_q[rs1_idx_d_i] && !(clr_now && (rd_idx_w_i == rs1_idx_d_i));
    assign rs2_pend  = pending_q[rs2_idx_d_i] && !(clr_now && (rd_idx_w_i == rs2_idx_d_i));
    assign stall_d_o = (rs1_used_d_i && rs1_pend) || (rs2_used_d_i && rs2_pend);

endmodule

// File: doc/regfile_wb_sink.md
Name: regfile_wb_sink

Overview:
- Integer register file: 32 x 32-bit, in the ID stage. It is the receiving end of the write-back interface driven by the WB stage.
- Accepts one write per cycle from WB.
- Serves two combinational read ports to decode, with same-cycle write-through bypass.
- Keeps a per-register load-pending scoreboard. Decode uses it to stall consumers of in-flight loads until their data reaches WB.

Parameters:
- XLEN, 32, data width of each register and of all data ports
- BYPASS_EN, 1, 1 = a WB write to the register being read is forwarded on the same cycle; 0 = the read returns the old array value

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- reg_write_en_w_i  input  1  write-back enable from WB
- rd_idx_w_i  input  5  write-back register index
- write_back_data_w_i  input  XLEN  write-back data
- wb_is_load_w_i  input  1  the current WB write is the result of a load (clears the scoreboard)
- rs1_idx_d_i  input  5  read port 1 index
- rs2_idx_d_i  input  5  read port 2 index
- rs1_data_d_o  output  XLEN  read port 1 data
- rs2_data_d_o  output  XLEN  read port 2 data
- load_issue_en_d_i  input  1  a load leaves ID this cycle (asserted only when not stalled)
- load_rd_idx_d_i  input  5  destination index of that load
- rs1_used_d_i  input  1  the instruction in ID actually reads rs1
- rs2_used_d_i  input  1  the instruction in ID actually reads rs2
- stall_d_o  output  1  the instruction in ID must hold; a register it uses has a pending load

Behaviour:
- State:
  - regs[1..31], XLEN bits each.
  - pending[1..31], 1 bit each.
  - x0 has no storage: it always reads 0 and is never pending.
- Reset (synchronous):
  - When reset=1 at a clock edge, all regs and all pending bits clear to 0.
  - A write or issue in that same cycle is ignored.
  - After reset: rs1_data_d_o = rs2_data_d_o = 0 and stall_d_o = 0.
  - Reset asserted mid-operation discards all in-flight scoreboard state; the pipeline is flushed by its own reset.
- Write:
  - At the edge, if reg_write_en_w_i=1 and rd_idx_w_i != 0, then regs[rd_idx_w_i] <= write_back_data_w_i.
  - A write to x0 is dropped.
- Read (combinational, zero latency):
  - Index 0 returns 0.
  - Otherwise, when BYPASS_EN=1, reg_write_en_w_i=1 and rd_idx_w_i equals the read index, the port returns write_back_data_w_i.
  - Otherwise the port returns regs[idx].
  - Both ports bypass independently, including when rs1 = rs2 = rd.
- Scoreboard update, at each edge unless reset:
  - Set: if load_issue_en_d_i=1 and load_rd_idx_d_i != 0, pending[load_rd_idx_d_i] <= 1.
  - Clear: if reg_write_en_w_i=1, wb_is_load_w_i=1 and rd_idx_w_i != 0, pending[rd_idx_w_i] <= 0.
  - Set and clear on the same index in the same cycle: set wins, because the newer load is still outstanding.
  - Set and clear on different indices both take effect.
  - A non-load WB write never clears a pending bit.
  - Pending is one bit per register. At most one outstanding load per rd is a pipeline invariant; a second issue to an already-pending rd leaves the bit set.
- Stall (combinational):
  - stall_d_o = (rs1_used_d_i & pending[rs1_idx_d_i]) | (rs2_used_d_i & pending[rs2_idx_d_i]).
  - The term for index 0 is always 0.
  - A clear arriving in the current cycle counts as resolved (same-cycle bypass): if reg_write_en_w_i & wb_is_load_w_i & (rd_idx_w_i == idx), that index does not stall.
  - This early-release applies only when BYPASS_EN=1; when BYPASS_EN=0 the stall holds until the cycle after the clear.
- No other latency: a write is visible through the array on the next cycle, or the same cycle via bypass.

Test Plan:
- Reset, then read x0..x31 on both ports -> every read returns 0; stall_d_o = 0.
- Write x5 = 0xDEADBEEF; the next cycle rs1 = 5 -> 0xDEADBEEF. Write x0 = 0x1234 -> x0 still reads 0. Write x7 = 0xA5A5A5A5 with rs1 = rs2 = 7 in the same cycle -> both ports return 0xA5A5A5A5 (BYPASS_EN=1), or the old value (BYPASS_EN=0).
- Issue a load to x9; the next cycle rs2 = 9 with rs2_used = 1 -> stall_d_o = 1. Repeat with rs2_used = 0 -> stall_d_o = 0. Non-load WB write to x9 -> still stalls. Load WB to x9 with data 0x55 -> stall_d_o = 0 that cycle and rs2_data = 0x55.
- Same cycle: load WB clears x3 and a new load issues to x3 -> x3 remains pending the next cycle. Load WB clears x3 while issue targets x4 -> x3 is clear and x4 is pending.
- Load issue to x0 -> never pending; rs1 = 0 with used = 1 -> no stall.
- Set pending on x10 and x11, assert reset together with a write of x12 = 1 -> after the edge no register is pending and x12 reads 0.
